palette_matcher: RTL
====================

PALETTE_MATCHER -- requirements
Module: palette_matcher

Interface
REQ-001 The block SHALL have no parameters; palette depth (16) and channel width (4) are fixed package constants.
REQ-002 Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request carries a 12-bit colour to quantize.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 red_in, green_in, blue_in  input  4 each  colour to match.
REQ-007 out_valid  output  1  result fields are valid.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 index  output  4  palette index nearest to the accepted colour.
REQ-010 distance  output  10  squared RGB distance to that entry.
REQ-011 exact  output  1  high when distance is 0.

Function
REQ-012 The block SHALL implement the inverse of the 16-entry sprite palette lookup: colour in, nearest palette index out.
REQ-013 States SHALL be IDLE, SEARCH and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request is accepted on a rising edge with in_valid=1 in IDLE; red/green/blue SHALL be latched then; later input changes are ignored until the next accept.
REQ-016 On accept: go to SEARCH, entry counter=0, best distance=1023, best index=0.
REQ-017 In SEARCH, one entry SHALL be evaluated per cycle, entries 0..15 in order: d = (dr^2)+(dg^2)+(db^2), with each |diff| 4 bits, each square 8 bits, and the sum 10 bits (max 675, no overflow).
REQ-018 The best entry SHALL update only when d < best distance (strict), so ties resolve to the lowest index.
REQ-019 After entry 15 is evaluated, the state SHALL go to DONE. out_valid rises exactly 16 cycles after the accepting edge. Latency is fixed; there is no early exit on an exact match.
REQ-020 In DONE, index, distance and exact SHALL remain stable while out_ready=0.
REQ-021 In DONE with out_ready=1, the edge SHALL return the block to IDLE. A new request cannot be accepted on that same edge, so the minimum throughput is one result per 18 cycles.
REQ-022 Outside DONE, index, distance and exact SHALL hold their last result values.
REQ-023 The counter SHALL not wrap into a second pass: reaching 15 forces DONE.

Reset
REQ-024 When Reset_n=0, the block SHALL immediately and asynchronously enter IDLE and set the counter to 0, index to 0, distance to 0, exact to 0 and out_valid to 0. in_ready becomes 1 once in IDLE.
REQ-025 A reset during SEARCH or DONE SHALL discard the pending request with no result emitted.
REQ-026 The first accept SHALL be possible on the first rising edge after Reset_n deasserts.

Structure
REQ-027 A shared package SHALL hold:
- the 16-entry palette constant (the same table used by the palette lookup)
- PAL_ENTRIES = 16 and CH_W = 4
- the state enum type.
REQ-028 Palette entries 0..15 (RGB hex) SHALL be: FFF, FA1, 442, EAA, 765, FD0, F41, 831, ECC, F71, E65, C41, A99, 221, FEE, E97.
REQ-029 One sub-module, palette_sqdist, SHALL compute the combinational squared distance between two 12-bit colours; the FSM, counter and best-tracking registers stay in palette_matcher.

Verification
REQ-030 Input (F,F,F) -> index 0, distance 0, exact 1; out_valid rises 16 cycles after accept.
REQ-031 Input (0,0,0) -> index 13, distance 9, exact 0.
REQ-032 Input (F,F,E), equidistant to entries 0 and 14 -> index 0, distance 1 (tie to the lower index).
REQ-033 Input (E,9,7) -> index 15, distance 0: the last entry is evaluated and no early exit occurs.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while changing the inputs and holding in_valid=1 -> outputs stable, in_ready=0; release -> IDLE, then the next request is accepted one edge later.
REQ-035 Assert Reset_n=0 mid-SEARCH (cycle 7) -> out_valid=0, state IDLE immediately; no stale result after release; a fresh request (2,2,1) -> index 13, distance 0.

Source files
------------

// File: rtl/palette_matcher_pkg.sv
// Shared definitions for the palette matcher.
// Holds the fixed 16-entry sprite palette (the same table the forward palette
// lookup uses), the palette/channel size constants and the FSM state type.
package palette_matcher_pkg;

    localparam int PAL_ENTRIES = 16;
    localparam int CH_W        = 4;
    localparam int COL_W       = 3 * CH_W;
    localparam int IDX_W       = 4;
    localparam int DIST_W      = 10;

    // Packed table: entry 0 sits in the least significant 12 bits, so the
    // literal below lists entry 15 first.
    localparam logic [PAL_ENTRIES-1:0][COL_W-1:0] PALETTE = {
        12'hE97, 12'hFEE, 12'h221, 12'hA99,
        12'hC41, 12'hE65, 12'hF71, 12'hECC,
        12'h831, 12'hF41, 12'hFD0, 12'h765,
        12'hEAA, 12'h442, 12'hFA1, 12'hFFF
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/palette_sqdist.sv
// Combinational squared RGB distance between two 12-bit colours.
// Ports:
//   a_i, b_i : colours as {R[11:8], G[7:4], B[3:0]}
//   dist_o   : dr^2 + dg^2 + db^2 (max 3*15^2 = 675, fits 10 bits)
module palette_sqdist
    import palette_matcher_pkg::*;
(
    input  logic [COL_W-1:0]  a_i,
    input  logic [COL_W-1:0]  b_i,
    output logic [DIST_W-1:0] dist_o
);

    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] x,
                                                  input logic [CH_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [2*CH_W-1:0] square(input logic [CH_W-1:0] d);
        return {{CH_W{1'b0}}, d} * {{CH_W{1'b0}}, d};
    endfunction

    logic [CH_W-1:0]   dr, dg, db;
    logic [2*CH_W-1:0] sr, sg, sb;

    always_comb begin
        dr     = abs_diff(a_i[11:8], b_i[11:8]);
        dg     = abs_diff(a_i[7:4],  b_i[7:4]);
        db     = abs_diff(a_i[3:0],  b_i[3:0]);
        sr     = square(dr);
        sg     = square(dg);
        sb     = square(db);
        dist_o = {2'b00, sr} + {2'b00, sg} + {2'b00, sb};
    end

endmodule

// File: rtl/palette_matcher.sv
// Inverse palette lookup: quantizes a 12-bit RGB colour to the nearest entry
// of the fixed 16-entry palette by scanning one entry per cycle.
// Ports:
//   Clk, Reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   red_in/green_in/blue_in : colour to match, latched on accept
//   out_valid / out_ready: result handshake (valid only in DONE)
//   index, distance, exact : nearest entry, its squared distance, distance==0
// Latency is a fixed 16 cycles from the accepting edge to out_valid.
module palette_matcher
    import palette_matcher_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   red_in,
    input  logic [CH_W-1:0]   green_in,
    input  logic [CH_W-1:0]   blue_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  index,
    output logic [DIST_W-1:0] distance,
    output logic              exact
);

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [COL_W-1:0]  color_q;
    logic [DIST_W-1:0] best_dist_q, best_dist_d;
    logic [IDX_W-1:0]  best_idx_q,  best_idx_d;
    logic [IDX_W-1:0]  index_q;
    logic [DIST_W-1:0] dist_q;
    logic              exact_q;
    logic              out_valid_q;

    logic [DIST_W-1:0] cur_dist;

    palette_sqdist u_sqdist (
        .a_i    (color_q),
        .b_i    (PALETTE[cnt_q]),
        .dist_o (cur_dist)
    );

    // Strict less-than keeps the earliest entry on ties.
    always_comb begin
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        if (cur_dist < best_dist_q) begin
            best_dist_d = cur_dist;
            best_idx_d  = cnt_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            color_q     <= '0;
            best_dist_q <= '1;
            best_idx_q  <= '0;
            index_q     <= '0;
            dist_q      <= '0;
            exact_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        color_q     <= {red_in, green_in, blue_in};
                        cnt_q       <= '0;
                        best_dist_q <= '1;
                        best_idx_q  <= '0;
                        state_q     <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    best_dist_q <= best_dist_d;
                    best_idx_q  <= best_idx_d;
                    // The last entry ends the scan; the counter never wraps.
                    if (cnt_q == IDX_W'(PAL_ENTRIES - 1)) begin
                        index_q     <= best_idx_d;
                        dist_q      <= best_dist_d;
                        exact_q     <= (best_dist_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign index     = index_q;
    assign distance  = dist_q;
    assign exact     = exact_q;

endmodule
